// File: rtl/sdram_arb_pkg.sv
// Shared defaults and master identifiers for the two-port SDRAM arbiter.
package sdram_arb_pkg;

    localparam int ADDR_W_DEF     = 22;
    localparam int DATA_W_DEF     = 32;
    localparam int PEND_DEPTH_DEF = 8;

    typedef enum logic {
        MID_M0 = 1'b0,
        MID_M1 = 1'b1
    } master_id_t;

    function automatic master_id_t other_master(input master_id_t id);
        return (id == MID_M0) ? MID_M1 : MID_M0;
    endfunction

endpackage

// File: rtl/sdram_arb_id_fifo.sv
// Small synchronous FIFO of master IDs, one entry per outstanding read,
// so pipelined read returns can be steered back to their issuer in order.
module sdram_arb_id_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = PEND_DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  master_id_t       push_id,
    input  logic             pop,
    output master_id_t       head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    master_id_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= MID_M0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-master Avalon-MM arbiter in front of the SDRAM controller slave:
// per-transfer round-robin, stall lock, and read-return steering.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int PEND_DEPTH = PEND_DEPTH_DEF,
    localparam int BE_W  = DATA_W / 8,
    localparam int CNT_W = $clog2(PEND_DEPTH) + 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,
    input  logic              s_waitrequest,

    output logic [CNT_W-1:0]  pending_count,
    output logic              err_orphan
);

    master_id_t       rr_ptr;
    master_id_t       lock_id;
    master_id_t       sel;
    master_id_t       fifo_head;
    logic             lock_q;
    logic             grant;
    logic             read_room;
    logic             elig_m0;
    logic             elig_m1;
    logic             sel_read;
    logic             sel_write;
    logic             s_accept;
    logic             fifo_empty;
    logic             fifo_full;
    logic             rdv_steer;
    logic [CNT_W-1:0] fifo_count;

    // Read eligibility uses the registered occupancy, so a return in the
    // same cycle does not free a slot until the next cycle.
    assign read_room = !fifo_full;
    assign elig_m0   = m0_write || (m0_read && read_room);
    assign elig_m1   = m1_write || (m1_read && read_room);

    always_comb begin
        sel   = MID_M0;
        grant = 1'b0;
        if (lock_q) begin
            sel   = lock_id;
            grant = (lock_id == MID_M1) ? elig_m1 : elig_m0;
        end else if (elig_m0 && elig_m1) begin
            sel   = other_master(rr_ptr);
            grant = 1'b1;
        end else if (elig_m0) begin
            sel   = MID_M0;
            grant = 1'b1;
        end else if (elig_m1) begin
            sel   = MID_M1;
            grant = 1'b1;
        end
        if (reset_reset) begin
            grant = 1'b0;
        end
    end

    assign sel_read     = (sel == MID_M1) ? m1_read       : m0_read;
    assign sel_write    = (sel == MID_M1) ? m1_write      : m0_write;
    assign s_address    = (sel == MID_M1) ? m1_address    : m0_address;
    assign s_writedata  = (sel == MID_M1) ? m1_writedata  : m0_writedata;
    assign s_byteenable = (sel == MID_M1) ? m1_byteenable : m0_byteenable;
    assign s_read       = grant && sel_read;
    assign s_write      = grant && sel_write;
    assign s_accept     = (s_read || s_write) && !s_waitrequest;

    assign m0_waitrequest = !(grant && (sel == MID_M0)) || s_waitrequest;
    assign m1_waitrequest = !(grant && (sel == MID_M1)) || s_waitrequest;

    // A stalled command keeps ownership of the slave until it is accepted.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            rr_ptr     <= MID_M1;
            lock_q     <= 1'b0;
            lock_id    <= MID_M0;
            err_orphan <= 1'b0;
        end else begin
            lock_q  <= (s_read || s_write) && s_waitrequest;
            lock_id <= sel;
            if (s_accept) begin
                rr_ptr <= sel;
            end
            if (s_readdatavalid && fifo_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

    sdram_arb_id_fifo #(
        .DEPTH (PEND_DEPTH)
    ) u_id_fifo (
        .clk     (clk_clk),
        .rst     (reset_reset),
        .push    (s_read && !s_waitrequest),
        .push_id (sel),
        .pop     (s_readdatavalid),
        .head    (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rdv_steer        = s_readdatavalid && !fifo_empty && !reset_reset;
    assign m0_readdatavalid = rdv_steer && (fifo_head == MID_M0);
    assign m1_readdatavalid = rdv_steer && (fifo_head == MID_M1);
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign pending_count    = fifo_count;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: directed scenarios plus randomized
// masters and a randomly stalling, randomly returning SDRAM slave model.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
    import sdram_arb_pkg::*;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    logic              clk_clk = 1'b0;
    logic              reset_reset;
    logic [ADDR_W-1:0] m0_address, m1_address, s_address;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable, s_byteenable;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic              s_read, s_write, s_readdatavalid, s_waitrequest;
    logic [CNT_W-1:0]  pending_count;
    logic              err_orphan;

    always #5 clk_clk = ~clk_clk;

    sdram_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .PEND_DEPTH (DEPTH)
    ) dut (
        .clk_clk          (clk_clk),
        .reset_reset      (reset_reset),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_byteenable    (m0_byteenable),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_readdata       (s_readdata),
        .s_readdatavalid  (s_readdatavalid),
        .s_waitrequest    (s_waitrequest),
        .pending_count    (pending_count),
        .err_orphan       (err_orphan)
    );

    typedef struct {
        logic              is_write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } cmd_t;

    cmd_t              cmd_exp[$];
    logic [DATA_W-1:0] exp_data0[$];
    logic [DATA_W-1:0] exp_data1[$];
    logic [DATA_W-1:0] ret_q[$];
    int                owner_q[$];

    int                n_checks = 0;
    int                n_pass   = 0;
    int                pend     = 0;
    bit                model_orphan = 1'b0;
    int                starve[2];
    bit                acc_flag[2];
    bit                prev_stall = 1'b0;
    logic [1:0]        prev_rw;
    logic [ADDR_W-1:0] prev_addr;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        $display("[TB] FAIL %s: event did not occur as required at %0t", name, $time);
    endtask

    // Slave memory content: every read returns a fixed function of its address.
    function automatic logic [DATA_W-1:0] slave_data(input logic [ADDR_W-1:0] a);
        return (DATA_W'(a) * 32'h9E3779B1) ^ 32'h5A5A_1234;
    endfunction

    // Monitor: master-side accepts push expectations, slave-side activity pops them.
    always @(negedge clk_clk) begin : monitor
        cmd_t       c;
        int         own;
        bit         new_orphan;
        int         inc, dec;
        logic [1:0] mr, mw;
        if (reset_reset) begin
            cmd_exp.delete(); exp_data0.delete(); exp_data1.delete();
            ret_q.delete(); owner_q.delete();
            pend = 0; model_orphan = 1'b0; prev_stall = 1'b0;
            starve[0] = 0; starve[1] = 0; acc_flag[0] = 1'b0; acc_flag[1] = 1'b0;
        end else begin
            inc = 0; dec = 0; new_orphan = 1'b0;
            mr = {m1_read, m0_read};
            mw = {m1_write, m0_write};
            check_output("pending_count", pending_count, pend);
            check_output("err_orphan", err_orphan, model_orphan);
            if (prev_stall) begin
                check_output("stall_hold_rw", {s_read, s_write}, prev_rw);
                check_output("stall_hold_addr", s_address, prev_addr);
            end
            acc_flag[0] = (m0_read || m0_write) && !m0_waitrequest;
            acc_flag[1] = (m1_read || m1_write) && !m1_waitrequest;
            check_output("accept_count", int'(acc_flag[0]) + int'(acc_flag[1]),
                         ((s_read || s_write) && !s_waitrequest) ? 1 : 0);
            for (int m = 0; m < 2; m++) begin
                if (acc_flag[m]) begin
                    c.is_write = mw[m];
                    c.addr     = (m == 0) ? m0_address    : m1_address;
                    c.data     = (m == 0) ? m0_writedata  : m1_writedata;
                    c.be       = (m == 0) ? m0_byteenable : m1_byteenable;
                    cmd_exp.push_back(c);
                    if (!c.is_write) begin
                        check_output("read_room", pend < DEPTH, 1'b1);
                        owner_q.push_back(m);
                        if (m == 0) exp_data0.push_back(slave_data(c.addr));
                        else        exp_data1.push_back(slave_data(c.addr));
                        inc = 1;
                    end
                end
            end
            if ((s_read || s_write) && !s_waitrequest) begin
                if (cmd_exp.size() == 0) fail_event("slave_cmd_unexpected");
                else begin
                    c = cmd_exp.pop_front();
                    check_output("s_cmd_kind", s_write, c.is_write);
                    check_output("s_address", s_address, c.addr);
                    if (c.is_write) begin
                        check_output("s_writedata", s_writedata, c.data);
                        check_output("s_byteenable", s_byteenable, c.be);
                    end else begin
                        ret_q.push_back(slave_data(s_address));
                    end
                end
            end
            if (s_readdatavalid) begin
                if (owner_q.size() == 0) begin
                    check_output("orphan_no_valid", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
                    new_orphan = 1'b1;
                end else begin
                    own = owner_q.pop_front();
                    check_output("rdv_m0", m0_readdatavalid, own == 0);
                    check_output("rdv_m1", m1_readdatavalid, own == 1);
                    if (own == 0) check_output("m0_readdata", m0_readdata, exp_data0.pop_front());
                    else          check_output("m1_readdata", m1_readdata, exp_data1.pop_front());
                    dec = 1;
                end
            end else begin
                check_output("rdv_idle", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
            end
            // Round-robin: a continuously eligible master never sees two grants go elsewhere.
            for (int m = 0; m < 2; m++) begin
                if (acc_flag[m] || !(mw[m] || (mr[m] && pend < DEPTH))) starve[m] = 0;
                else if (acc_flag[1-m]) begin
                    starve[m]++;
                    check_output((m == 0) ? "fair_m0" : "fair_m1", starve[m] < 2, 1'b1);
                end
            end
            prev_stall = (s_read || s_write) && s_waitrequest;
            prev_rw    = {s_read, s_write};
            prev_addr  = s_address;
            pend = pend + inc - dec;
            if (new_orphan) model_orphan = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk_clk); #1;
    endtask

    task automatic sample();
        @(negedge clk_clk); #1;
    endtask

    task automatic wait_accept(input int m, input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            sample();
            ok = acc_flag[m];
            tick();
        end
        if (!ok) fail_event(name);
    endtask

    task automatic drain_returns();
        for (int k = 0; k < 40 && ret_q.size() != 0; k++) begin
            s_readdatavalid = 1'b1;
            s_readdata      = ret_q.pop_front();
            tick();
        end
        s_readdatavalid = 1'b0;
    endtask

    task automatic drive_master(input int m, input bit on);
        logic busy, rd, wr;
        busy = (m == 0) ? ((m0_read || m0_write) && !acc_flag[0])
                        : ((m1_read || m1_write) && !acc_flag[1]);
        if (busy) return;
        rd = 1'b0; wr = 1'b0;
        if (on && $urandom_range(0, 9) < 7) begin
            if ($urandom_range(0, 1) == 1) rd = 1'b1;
            else                           wr = 1'b1;
        end
        if (m == 0) begin
            m0_read = rd; m0_write = wr;
            m0_address    = ADDR_W'($urandom_range(0, 1023));
            m0_writedata  = $urandom;
            m0_byteenable = BE_W'($urandom_range(1, 15));
        end else begin
            m1_read = rd; m1_write = wr;
            m1_address    = ADDR_W'($urandom_range(0, 1023));
            m1_writedata  = $urandom;
            m1_byteenable = BE_W'($urandom_range(1, 15));
        end
    endtask

    task automatic apply_stimulus(input int cycles, input bit masters_on);
        for (int cyc = 0; cyc < cycles; cyc++) begin
            tick();
            drive_master(0, masters_on);
            drive_master(1, masters_on);
            s_waitrequest = ($urandom_range(0, 3) == 0);
            if (ret_q.size() != 0 && $urandom_range(0, 2) == 0) begin
                s_readdatavalid = 1'b1;
                s_readdata      = ret_q.pop_front();
            end else begin
                s_readdatavalid = 1'b0;
                s_readdata      = $urandom;
            end
        end
        tick();
        s_readdatavalid = 1'b0;
        s_waitrequest   = 1'b0;
    endtask

    initial begin
        reset_reset   = 1'b1;
        m0_address    = ADDR_W'('h10); m0_read = 1'b1; m0_write = 1'b0;
        m1_address    = ADDR_W'('h20); m1_read = 1'b1; m1_write = 1'b0;
        m0_writedata  = '0; m1_writedata = '0;
        m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        s_readdata    = '0; s_readdatavalid = 1'b0; s_waitrequest = 1'b0;

        // Reset state, with both masters already requesting
        sample();
        check_output("rst_s_read", s_read, 1'b0);
        check_output("rst_s_write", s_write, 1'b0);
        check_output("rst_m0_wait", m0_waitrequest, 1'b1);
        check_output("rst_m1_wait", m1_waitrequest, 1'b1);
        check_output("rst_pending", pending_count, 0);
        check_output("rst_err_orphan", err_orphan, 1'b0);
        check_output("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
        tick();
        reset_reset = 1'b0;

        // Both masters read: m0 wins first, returns steered in order
        sample();
        check_output("t1_first_s_read", s_read, 1'b1);
        check_output("t1_first_addr", s_address, 'h10);
        check_output("t1_m1_wait", m1_waitrequest, 1'b1);
        tick();
        m0_read = 1'b0;
        sample();
        check_output("t1_second_addr", s_address, 'h20);
        check_output("t1_m1_granted", m1_waitrequest, 1'b0);
        tick();
        m1_read = 1'b0;
        s_readdatavalid = 1'b1;
        s_readdata = ret_q.pop_front();
        sample();
        check_output("t1_pending2", pending_count, 2);
        check_output("t1_m0_rdv", m0_readdatavalid, 1'b1);
        check_output("t1_m0_data", m0_readdata, slave_data('h10));
        tick();
        s_readdata = ret_q.pop_front();
        sample();
        check_output("t1_m1_rdv", m1_readdatavalid, 1'b1);
        check_output("t1_m1_data", m1_readdata, slave_data('h20));
        tick();
        s_readdatavalid = 1'b0;

        // Push and pop in the same cycle at occupancy 4
        m0_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m0_address = ADDR_W'('h200 + i);
            wait_accept(0, "t5_fill_accept");
        end
        m0_read = 1'b0;
        m1_read = 1'b1; m1_address = ADDR_W'('h300);
        s_readdatavalid = 1'b1;
        s_readdata = ret_q.pop_front();
        sample();
        check_output("t5_s_read", s_read, 1'b1);
        check_output("t5_m0_rdv", m0_readdatavalid, 1'b1);
        tick();
        m1_read = 1'b0;
        s_readdatavalid = 1'b0;
        sample();
        check_output("t5_pending_same", pending_count, 4);
        tick();
        drain_returns();

        // Pending table full: 9th read held, writes still pass
        m1_read = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            m1_address = ADDR_W'('h100 + i);
            wait_accept(1, "t4_fill_accept");
        end
        m1_address = ADDR_W'('h108);
        m0_write = 1'b1; m0_address = ADDR_W'('h55); m0_writedata = 32'hCAFE_0055;
        sample();
        check_output("t4_full_count", pending_count, DEPTH);
        check_output("t4_read_held", s_read, 1'b0);
        check_output("t4_m1_wait", m1_waitrequest, 1'b1);
        check_output("t4_write_pass", s_write, 1'b1);
        check_output("t4_m0_wait", m0_waitrequest, 1'b0);
        tick();
        m0_write = 1'b0;
        s_readdatavalid = 1'b1;
        s_readdata = ret_q.pop_front();
        sample();
        check_output("t4_pop_no_unblock", s_read, 1'b0);
        tick();
        s_readdatavalid = 1'b0;
        sample();
        check_output("t4_read_issued", s_read, 1'b1);
        check_output("t4_read_addr", s_address, 'h108);
        tick();
        m1_read = 1'b0;
        drain_returns();

        // Randomized traffic, then a quiet period to let returns drain
        apply_stimulus(2500, 1'b1);
        apply_stimulus(300, 1'b0);
        check_output("drained_pending", pending_count, 0);

        // Reset with reads pending, then a late return
        m0_read = 1'b1; m1_read = 1'b0; m0_write = 1'b0; m1_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m0_address = ADDR_W'('h400 + i);
            wait_accept(0, "t6_fill_accept");
        end
        m0_read = 1'b0;
        check_output("t6_pending3", pending_count, 3);
        reset_reset = 1'b1;
        sample();
        check_output("t6_rst_pending", pending_count, 0);
        tick();
        reset_reset = 1'b0;
        s_readdatavalid = 1'b1;
        s_readdata = 32'hDEAD_BEEF;
        sample();
        check_output("t6_no_m0_rdv", m0_readdatavalid, 1'b0);
        check_output("t6_no_m1_rdv", m1_readdatavalid, 1'b0);
        tick();
        s_readdatavalid = 1'b0;
        sample();
        check_output("t6_err_orphan", err_orphan, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
